// File: rtl/exec_pkg.sv
// Shared definitions for the EX-stage execute unit: op codes, FSM states and
// small op-class decode helpers.
package exec_pkg;

  localparam logic [4:0] OP_ADD    = 5'd0;
  localparam logic [4:0] OP_SUB    = 5'd1;
  localparam logic [4:0] OP_SLL    = 5'd2;
  localparam logic [4:0] OP_SLT    = 5'd3;
  localparam logic [4:0] OP_SLTU   = 5'd4;
  localparam logic [4:0] OP_XOR    = 5'd5;
  localparam logic [4:0] OP_SRL    = 5'd6;
  localparam logic [4:0] OP_SRA    = 5'd7;
  localparam logic [4:0] OP_OR     = 5'd8;
  localparam logic [4:0] OP_AND    = 5'd9;
  localparam logic [4:0] OP_PASS_B = 5'd10;
  localparam logic [4:0] OP_MUL    = 5'd16;
  localparam logic [4:0] OP_MULH   = 5'd17;
  localparam logic [4:0] OP_MULHSU = 5'd18;
  localparam logic [4:0] OP_MULHU  = 5'd19;
  localparam logic [4:0] OP_DIV    = 5'd20;
  localparam logic [4:0] OP_DIVU   = 5'd21;
  localparam logic [4:0] OP_REM    = 5'd22;
  localparam logic [4:0] OP_REMU   = 5'd23;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  // Multiply ops occupy 16..19 and divide ops 20..23.
  function automatic logic is_mul_op(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction

  function automatic logic is_div_op(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction

endpackage

// File: rtl/alu_iterative_exec_mdu_core.sv
// Iterative multiply/divide engine: one bit per cycle, shift-add multiply and
// restoring divide on magnitudes, with sign fix-up on the final step.
module mdu_iter_core
  #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
  )
  (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            clear,
    input  logic            is_div,
    input  logic            a_signed,
    input  logic            b_signed,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            done,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
  );

  logic              running;
  logic              op_div;
  logic              neg_lo;
  logic              neg_hi;
  logic [CNT_W-1:0]  cnt;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_next;
  logic [XLEN-1:0]   opnd;
  logic              a_neg;
  logic              b_neg;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;
  logic [XLEN:0]     sum;
  logic [XLEN:0]     shifted;
  logic [XLEN:0]     diff;
  logic [XLEN-1:0]   q;
  logic [XLEN-1:0]   r;

  assign a_neg = a_signed && a[XLEN-1];
  assign b_neg = b_signed && b[XLEN-1];
  assign mag_a = a_neg ? -a : a;
  assign mag_b = b_neg ? -b : b;

  // acc holds {partial product, multiplier} or {partial remainder, dividend/quotient}.
  always_comb begin
    sum     = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd} : {(XLEN+1){1'b0}});
    shifted = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff    = shifted - {1'b0, opnd};
    if (op_div) begin
      acc_next = diff[XLEN] ? {shifted[XLEN-1:0], acc[XLEN-2:0], 1'b0}
                            : {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
    end else begin
      acc_next = {sum, acc[XLEN-1:1]};
    end
  end

  assign q    = acc_next[XLEN-1:0];
  assign r    = acc_next[2*XLEN-1:XLEN];
  assign done = running && (cnt == CNT_W'(XLEN - 1));

  // Outputs are the fixed-up value of the step in progress so the caller can
  // register the answer on the same edge as the last iteration.
  always_comb begin
    if (op_div) begin
      hi = neg_hi ? -r : r;
      lo = neg_lo ? -q : q;
    end else begin
      {hi, lo} = neg_lo ? -acc_next : acc_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running <= 1'b0;
      op_div  <= 1'b0;
      neg_lo  <= 1'b0;
      neg_hi  <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
    end else if (clear) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (start) begin
      running <= 1'b1;
      cnt     <= '0;
      op_div  <= is_div;
      acc     <= is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
      opnd    <= is_div ? mag_b : mag_a;
      neg_lo  <= a_neg ^ b_neg;
      neg_hi  <= a_neg;
    end else if (running) begin
      acc <= acc_next;
      cnt <= cnt + CNT_W'(1);
      if (done) begin
        running <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_iterative_exec.sv
// EX-stage execute unit: single-cycle RV32I ALU plus iterative RV32M engine,
// valid/ready on both sides and a synchronous flush.
module alu_iterative_exec
  import exec_pkg::*;
  #(
    parameter int XLEN     = 32,
    parameter int OP_W     = 5,
    parameter int ENABLE_M = 1,
    parameter int CNT_W    = $clog2(XLEN) + 1
  )
  (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [OP_W-1:0] alu_op,
    input  logic            d1_sel,
    input  logic            d2_sel,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [XLEN-1:0] immediate,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
  );

  localparam int SHW = $clog2(XLEN);
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t          state;
  logic [4:0]      op;
  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic [XLEN-1:0] base_res;
  logic [XLEN-1:0] imm_res;
  logic            m_en;
  logic            is_mul;
  logic            is_div;
  logic            sgn_a;
  logic            sgn_b;
  logic            div_special;
  logic            launch_iter;
  logic            accept;
  logic            sel_hi;
  logic            sel_hi_next;
  logic            core_start;
  logic            core_done;
  logic [XLEN-1:0] core_hi;
  logic [XLEN-1:0] core_lo;

  assign op     = 5'(alu_op);
  assign op_a   = d1_sel ? pc : rs1_data;
  assign op_b   = d2_sel ? immediate : rs2_data;
  assign m_en   = (ENABLE_M != 0);
  assign is_mul = m_en && is_mul_op(op);
  assign is_div = m_en && is_div_op(op);
  assign sgn_a  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
                  (op == OP_DIV) || (op == OP_REM);
  assign sgn_b  = (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  assign sel_hi_next = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU) ||
                       (op == OP_REM) || (op == OP_REMU);

  // Divide-by-zero and signed overflow finish immediately without iterating.
  assign div_special = is_div && ((op_b == '0) || (sgn_b && op_a == MIN_NEG && op_b == '1));
  assign launch_iter = (is_mul || is_div) && !div_special;

  assign in_ready   = (state == IDLE) || (state == DONE && out_ready);
  assign accept     = in_valid && in_ready && !flush;
  assign core_start = accept && launch_iter;

  always_comb begin
    base_res = '0;
    case (op)
      OP_ADD:    base_res = op_a + op_b;
      OP_SUB:    base_res = op_a - op_b;
      OP_SLL:    base_res = op_a << op_b[SHW-1:0];
      OP_SLT:    base_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU:   base_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:    base_res = op_a ^ op_b;
      OP_SRL:    base_res = op_a >> op_b[SHW-1:0];
      OP_SRA:    base_res = $signed(op_a) >>> op_b[SHW-1:0];
      OP_OR:     base_res = op_a | op_b;
      OP_AND:    base_res = op_a & op_b;
      OP_PASS_B: base_res = op_b;
      default:   base_res = '0;
    endcase
    imm_res = base_res;
    if (div_special) begin
      if (op == OP_DIV || op == OP_DIVU) begin
        imm_res = (op_b == '0) ? '1 : op_a;
      end else begin
        imm_res = (op_b == '0) ? op_a : '0;
      end
    end
  end

  mdu_iter_core #(.XLEN(XLEN), .CNT_W(CNT_W)) u_core (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (core_start),
    .clear    (flush),
    .is_div   (is_div),
    .a_signed (sgn_a),
    .b_signed (sgn_b),
    .a        (op_a),
    .b        (op_b),
    .done     (core_done),
    .hi       (core_hi),
    .lo       (core_lo)
  );

  // A new accept can only happen from IDLE or a draining DONE, so it is
  // handled ahead of the per-state work.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      result    <= '0;
      busy      <= 1'b0;
      sel_hi    <= 1'b0;
    end else if (flush) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else if (accept) begin
      sel_hi <= sel_hi_next;
      if (launch_iter) begin
        state     <= is_div ? DIV : MUL;
        busy      <= 1'b1;
        out_valid <= 1'b0;
      end else begin
        state     <= DONE;
        out_valid <= 1'b1;
        result    <= imm_res;
      end
    end else begin
      case (state)
        MUL, DIV: begin
          if (core_done) begin
            state     <= DONE;
            busy      <= 1'b0;
            out_valid <= 1'b1;
            result    <= sel_hi ? core_hi : core_lo;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iterative_exec.sv
// Self-checking bench for alu_iterative_exec: directed scenarios plus random
// ops compared against an arithmetic reference model.
module tb_alu_iterative_exec;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  alu_op;
  logic        d1_sel;
  logic        d2_sel;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [31:0] immediate;
  logic [31:0] pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  alu_iterative_exec #(.XLEN(32), .OP_W(5), .ENABLE_M(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .d1_sel    (d1_sel),
    .d2_sel    (d2_sel),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .immediate (immediate),
    .pc        (pc),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .busy      (busy)
  );

  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    logic signed [63:0] sp;
    logic [63:0]        up;
    case (op)
      5'd0:  return a + b;
      5'd1:  return a - b;
      5'd2:  return a << b[4:0];
      5'd3:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      5'd4:  return (a < b) ? 32'd1 : 32'd0;
      5'd5:  return a ^ b;
      5'd6:  return a >> b[4:0];
      5'd7:  return 32'($signed(a) >>> b[4:0]);
      5'd8:  return a | b;
      5'd9:  return a & b;
      5'd10: return b;
      5'd16, 5'd17: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
        return (op == 5'd16) ? sp[31:0] : sp[63:32];
      end
      5'd18: begin
        sp = $signed({{32{a[31]}}, a}) * $signed({32'b0, b});
        return sp[63:32];
      end
      5'd19: begin
        up = {32'b0, a} * {32'b0, b};
        return up[63:32];
      end
      5'd20: begin
        if (b == 32'd0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return 32'($signed(a) / $signed(b));
      end
      5'd21: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
      5'd22: begin
        if (b == 32'd0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return 32'($signed(a) % $signed(b));
      end
      5'd23: return (b == 32'd0) ? a : a % b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic int ref_latency(input logic [4:0] op, input logic [31:0] a,
                                     input logic [31:0] b);
    if (op >= 5'd16 && op <= 5'd19) return 33;
    if (op == 5'd20 || op == 5'd22) begin
      if (b == 32'd0 || (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) return 1;
      return 33;
    end
    if (op == 5'd21 || op == 5'd23) return (b == 32'd0) ? 1 : 33;
    return 1;
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request from a negedge and follows it to its result.
  task automatic apply_stimulus(input string tag, input logic [4:0] op, input logic d1,
                                input logic d2, input logic [31:0] rs1v,
                                input logic [31:0] rs2v, input logic [31:0] immv,
                                input logic [31:0] pcv);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          exp_lat;
    int          lat;
    int          busy_cnt;
    int          ready_bad;
    a        = d1 ? pcv : rs1v;
    b        = d2 ? immv : rs2v;
    exp      = ref_result(op, a, b);
    exp_lat  = ref_latency(op, a, b);
    alu_op    = op;
    d1_sel    = d1;
    d2_sel    = d2;
    rs1_data  = rs1v;
    rs2_data  = rs2v;
    immediate = immv;
    pc        = pcv;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    #1;
    check_output({tag, ":in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    alu_op    = 5'($urandom);
    rs1_data  = $urandom;
    rs2_data  = $urandom;
    immediate = $urandom;
    pc        = $urandom;
    lat       = 0;
    busy_cnt  = 0;
    ready_bad = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (busy && in_ready) ready_bad++;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    check_output({tag, ":result"}, result, exp);
    check_output({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, ":busy_cycles"}, 32'(busy_cnt), 32'(exp_lat - 1));
    check_output({tag, ":ready_in_busy"}, 32'(ready_bad), 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0]  op_list [21];
    logic [31:0] held;
    int          cnt;
    op_list = '{5'd0, 5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8, 5'd9, 5'd10,
                5'd16, 5'd17, 5'd18, 5'd19, 5'd20, 5'd21, 5'd22, 5'd23, 5'd11, 5'd27};

    rst_n = 1'b0; in_valid = 1'b0; alu_op = 5'd0; d1_sel = 1'b0; d2_sel = 1'b0;
    rs1_data = '0; rs2_data = '0; immediate = '0; pc = '0; flush = 1'b0; out_ready = 1'b1;
    #12;
    check_output("reset:out_valid", {31'b0, out_valid}, 32'd0);
    check_output("reset:busy", {31'b0, busy}, 32'd0);
    check_output("reset:result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_output("reset:in_ready", {31'b0, in_ready}, 32'd1);

    // Back-to-back base ops.
    @(negedge clk);
    alu_op = 5'd0; rs1_data = 32'h7FFF_FFFF; rs2_data = 32'd1; in_valid = 1'b1;
    @(posedge clk);
    #1;
    alu_op = 5'd1; rs1_data = 32'd5; rs2_data = 32'd7;
    @(negedge clk);
    check_output("b2b:add_valid", {31'b0, out_valid}, 32'd1);
    check_output("b2b:add_result", result, 32'h8000_0000);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    check_output("b2b:sub_valid", {31'b0, out_valid}, 32'd1);
    check_output("b2b:sub_result", result, 32'hFFFF_FFFE);
    @(negedge clk);
    check_output("b2b:drained", {31'b0, out_valid}, 32'd0);

    apply_stimulus("mulh", 5'd17, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    apply_stimulus("mulhu", 5'd19, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    apply_stimulus("mul", 5'd16, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    apply_stimulus("div", 5'd20, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 0);
    apply_stimulus("rem", 5'd22, 0, 0, 32'hFFFF_FFF9, 32'd2, 0, 0);
    apply_stimulus("divu", 5'd21, 0, 0, 32'd100, 32'd7, 0, 0);
    apply_stimulus("remu", 5'd23, 0, 0, 32'd100, 32'd7, 0, 0);
    apply_stimulus("divu_zero", 5'd21, 0, 0, 32'h1234_5678, 32'd0, 0, 0);
    apply_stimulus("rem_zero", 5'd22, 0, 0, 32'd9, 32'd0, 0, 0);
    apply_stimulus("div_ovf", 5'd20, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    apply_stimulus("rem_ovf", 5'd22, 0, 0, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
    apply_stimulus("unknown_op", 5'd13, 0, 0, 32'd1, 32'd2, 0, 0);

    // Backpressure after a multiply completes.
    @(negedge clk);
    alu_op = 5'd16; d1_sel = 1'b0; d2_sel = 1'b0;
    rs1_data = 32'h1234_5678; rs2_data = 32'h9ABC_DEF0; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    cnt = 0;
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (out_valid) begin
        cnt = c;
        break;
      end
    end
    check_output("bp:latency", 32'(cnt), 32'd33);
    held = ref_result(5'd16, 32'h1234_5678, 32'h9ABC_DEF0);
    alu_op = 5'd0; rs1_data = 32'd1; rs2_data = 32'd1; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_output("bp:hold_valid", {31'b0, out_valid}, 32'd1);
      check_output("bp:hold_result", result, held);
      check_output("bp:no_ready", {31'b0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check_output("bp:released", {31'b0, out_valid}, 32'd0);

    // Flush at iteration 10 of a divide.
    alu_op = 5'd21; rs1_data = 32'd100; rs2_data = 32'd7; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(negedge clk);
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    check_output("flush:out_valid", {31'b0, out_valid}, 32'd0);
    check_output("flush:busy", {31'b0, busy}, 32'd0);
    check_output("flush:in_ready", {31'b0, in_ready}, 32'd1);
    cnt = 0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid || busy) cnt++;
    end
    check_output("flush:stays_idle", 32'(cnt), 32'd0);

    // Flush wins over a same-cycle request.
    alu_op = 5'd0; rs1_data = 32'd3; rs2_data = 32'd4; in_valid = 1'b1; flush = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; flush = 1'b0;
    @(negedge clk);
    check_output("flush_prio:out_valid", {31'b0, out_valid}, 32'd0);

    // Async reset in the middle of a multiply.
    apply_stimulus("pre_reset_add", 5'd0, 0, 0, 32'd3, 32'd4, 0, 0);
    alu_op = 5'd19; rs1_data = 32'hDEAD_BEEF; rs2_data = 32'h0000_0123; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    check_output("areset:busy_before", {31'b0, busy}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_output("areset:out_valid", {31'b0, out_valid}, 32'd0);
    check_output("areset:busy", {31'b0, busy}, 32'd0);
    check_output("areset:result", result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    apply_stimulus("post_reset_add", 5'd0, 1, 1, 32'd0, 32'd0, 32'd4, 32'h100);

    for (int n = 0; n < 40; n++) begin
      apply_stimulus("random", op_list[$urandom_range(0, 20)], 1'($urandom), 1'($urandom),
                     pick_operand(), pick_operand(), pick_operand(), pick_operand());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_iterative_exec.md
Name: alu_iterative_exec

Overview:
- Parametrised next-generation execute unit. It performs the base RV32I ALU operations with one registered cycle.
- It adds an iterative RV32M multiply/divide engine: one bit per cycle, shift-add for multiply, restoring for divide.
- It sits in the EX stage and talks to the pipeline through valid/ready handshakes on both sides.
- A flush input aborts an in-flight operation.

Parameters:
- XLEN, 32, datapath width of operands and result (power of two, >= 8).
- OP_W, 5, width of the op select.
- ENABLE_M, 1, 1 = M-extension ops execute; 0 = M opcodes return 0 with base-op latency.
- CNT_W, $clog2(XLEN)+1, iteration counter width (derived, not to be overridden).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request this cycle
- alu_op  in  OP_W  operation select (codes in package)
- d1_sel  in  1  operand A select: 0 = rs1_data, 1 = pc
- d2_sel  in  1  operand B select: 0 = rs2_data, 1 = immediate
- rs1_data  in  XLEN  register source 1
- rs2_data  in  XLEN  register source 2
- immediate  in  XLEN  sign-extended immediate
- pc  in  XLEN  instruction address
- flush  in  1  synchronous abort of the current operation
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- result  out  XLEN  operation result
- busy  out  1  high in MUL or DIV iteration states

Behaviour:
- Reset is asynchronous: state=IDLE, out_valid=0, result=0, busy=0, counter=0, all internal accumulators 0.
- Handshake rules:
  - A request is accepted when in_valid && in_ready.
  - in_ready = (state==IDLE) || (state==DONE && out_ready), so back-to-back requests are supported.
  - Operands are muxed per d1_sel/d2_sel and captured at accept. Later input changes are ignored.
- States:
  - IDLE -> DONE on acceptance of a base op, an M op with ENABLE_M=0, or a DIV special case.
  - IDLE -> MUL for MUL/MULH/MULHSU/MULHU.
  - IDLE -> DIV for DIV/DIVU/REM/REMU.
  - MUL/DIV -> DONE when the counter reaches XLEN.
  - DONE -> IDLE on out_ready without a new accept; DONE -> IDLE/MUL/DIV on out_ready with a new accept.
- Base ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASS_B):
  - Result is registered at accept; out_valid rises the next cycle (latency 1).
  - Shift amount = B[$clog2(XLEN)-1:0]. SLT/SLTU produce 0/1 zero-extended.
- Multiply:
  - Operands are converted to magnitudes per signedness: MUL and MULH signed x signed, MULHSU signed x unsigned, MULHU unsigned.
  - The engine iterates XLEN cycles into a 2*XLEN product, then negates the product if the signs differ.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
  - out_valid is asserted XLEN+1 cycles after accept.
- Divide:
  - Restoring divide, XLEN iterations on magnitudes.
  - Quotient is negated if the operand signs differ (signed ops only); remainder takes the dividend's sign.
  - Latency XLEN+1.
- Divide special cases resolve at accept with latency 1 and no iteration:
  - Divisor 0: quotient = all ones, remainder = dividend.
  - Signed overflow (dividend = 1<<(XLEN-1), divisor = -1): quotient = dividend, remainder = 0.
- Output hold: while out_valid && !out_ready, result and out_valid hold stable. There is no drop and no overwrite.
- Flush:
  - Next state is IDLE; out_valid=0 and busy=0 next cycle; the counter clears.
  - flush has priority over accept in the same cycle; the request is not taken.
- Unknown alu_op codes produce result 0 with latency 1.
- Counter counts 0..XLEN in MUL/DIV and must not wrap past XLEN.

Decomposition:
- Shared package exec_pkg holds:
  - alu_op localparam codes: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASS_B=10, MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
  - State encoding: IDLE, MUL, DIV, DONE.
- Sub-module mdu_iter_core (parametrised by XLEN):
  - Holds the shared shift register, accumulator, counter and sign-fixup logic.
  - Interface: start, is_div, signed flags, done pulse, hi/lo outputs.
- The top level contains the operand mux, base ALU, FSM and output register.

Test Plan:
- Back-to-back base ops: ADD 0x7FFFFFFF+1 then SUB 5-7 with out_ready=1 -> results 0x80000000 then 0xFFFFFFFE on consecutive cycles, each 1 cycle after accept.
- MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000 at cycle 33; MULHU on the same operands -> 0xFFFFFFFE; MUL on the same operands -> 0x00000001. busy is high for 32 cycles and in_ready is low during iteration.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2; each with latency 33.
- Special cases: DIVU x/0 -> 0xFFFFFFFF; REM 9/0 -> 9; DIV 0x80000000/-1 -> 0x80000000; REM 0x80000000/-1 -> 0; each at latency 1 with busy never high.
- Backpressure and flush:
  - Hold out_ready=0 for 5 cycles after a MUL completes -> result stable and no accept.
  - Assert flush at iteration 10 of a DIV -> out_valid stays 0 and in_ready is 1 next cycle.
- Async reset: assert rst_n=0 mid-MUL, off a clock edge -> out_valid, busy and result are 0 immediately. After release, a fresh ADD 3+4 with d1_sel=1 (pc=0x100) and d2_sel=1 (imm=4) -> 0x104.
